// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// the helper that classifies which modes advance the word counter.
package shiftreg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    ROR  = 3'd3,
    ROL  = 3'd4,
    LOAD = 3'd5,
    SCLR = 3'd6,
    RSVD = 3'd7
  } mode_t;

  // Shifts and rotates both count as one step of a word.
  function automatic logic is_step(input mode_t m);
    return (m == SHR) || (m == SHL) || (m == ROR) || (m == ROL);
  endfunction

  // LOAD and SCLR start a fresh word.
  function automatic logic is_restart(input mode_t m);
    return (m == LOAD) || (m == SCLR);
  endfunction

endpackage

// File: rtl/shiftreg_word_counter.sv
// Counts shift/rotate steps modulo WIDTH and emits a registered one-cycle
// pulse on the step that completes a word.
module shiftreg_word_counter #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          en,
  input  logic          step,
  input  logic          restart,
  output logic [CW-1:0] cnt,
  output logic          word_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          word_done_reg, word_done_next;

  always_comb begin
    cnt_next       = cnt_reg;
    word_done_next = 1'b0;
    if (en) begin
      if (restart) begin
        cnt_next = '0;
      end else if (step) begin
        if (cnt_reg == LAST) begin
          cnt_next       = '0;
          word_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_reg       <= '0;
      word_done_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      word_done_reg <= word_done_next;
    end
  end

  assign cnt       = cnt_reg;
  assign word_done = word_done_reg;

endmodule

// File: rtl/shiftreg_universal.sv
// Parametrised universal shift register: mode-selected datapath with clock
// enable, serial taps from both ends and a word-completion counter.
module shiftreg_universal
  import shiftreg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              sin_msb,
  input  logic              sin_lsb,
  input  logic [WIDTH-1:0]  pdata,
  output logic [WIDTH-1:0]  q,
  output logic              sout_lsb,
  output logic              sout_msb,
  output logic [CW-1:0]     cnt,
  output logic              word_done
);

  mode_t            op;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             step;
  logic             restart;

  assign op      = mode_t'(mode);
  assign step    = is_step(op);
  assign restart = is_restart(op);

  always_comb begin
    q_next = q_reg;
    case (op)
      SHR:     q_next = {sin_msb, q_reg[WIDTH-1:1]};
      SHL:     q_next = {q_reg[WIDTH-2:0], sin_lsb};
      ROR:     q_next = {q_reg[0], q_reg[WIDTH-1:1]};
      ROL:     q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      LOAD:    q_next = pdata;
      SCLR:    q_next = '0;
      default: q_next = q_reg;  // HOLD and the reserved code
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= q_next;
    end
  end

  shiftreg_word_counter #(
    .WIDTH (WIDTH)
  ) u_word_counter (
    .clock     (clock),
    .clear     (clear),
    .en        (en),
    .step      (step),
    .restart   (restart),
    .cnt       (cnt),
    .word_done (word_done)
  );

  assign q        = q_reg;
  assign sout_lsb = q_reg[0];
  assign sout_msb = q_reg[WIDTH-1];

endmodule

// File: tb/tb_shiftreg_universal.sv
// Self-checking bench for shiftreg_universal (WIDTH=4): directed scenarios
// followed by randomized traffic against a step-count based reference model.
module tb_shiftreg_universal;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH);

  logic             clock   = 1'b0;
  logic             clear   = 1'b1;
  logic             en      = 1'b0;
  logic [2:0]       mode    = 3'd0;
  logic             sin_msb = 1'b0;
  logic             sin_lsb = 1'b0;
  logic [WIDTH-1:0] pdata   = '0;
  logic [WIDTH-1:0] q;
  logic             sout_lsb;
  logic             sout_msb;
  logic [CW-1:0]    cnt;
  logic             word_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model: register contents plus steps taken since the last restart.
  logic [WIDTH-1:0] m_q     = '0;
  int               m_steps = 0;
  bit               m_wd    = 1'b0;

  always #5 clock = ~clock;

  shiftreg_universal #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .clear     (clear),
    .en        (en),
    .mode      (mode),
    .sin_msb   (sin_msb),
    .sin_lsb   (sin_lsb),
    .pdata     (pdata),
    .q         (q),
    .sout_lsb  (sout_lsb),
    .sout_msb  (sout_msb),
    .cnt       (cnt),
    .word_done (word_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".q"},        32'(q),         32'(m_q));
    check({tag, ".cnt"},      32'(cnt),       32'(m_steps % WIDTH));
    check({tag, ".wd"},       32'(word_done), 32'(m_wd));
    check({tag, ".sout_lsb"}, 32'(sout_lsb),  32'(m_q[0]));
    check({tag, ".sout_msb"}, 32'(sout_msb),  32'(m_q[WIDTH-1]));
  endtask

  function automatic void model_apply(input bit e, input logic [2:0] m, input bit smsb,
                                      input bit slsb, input logic [WIDTH-1:0] pd);
    bit did_step;
    did_step = 1'b0;
    m_wd     = 1'b0;
    if (e) begin
      case (m)
        3'd1: begin m_q = (m_q >> 1) | (WIDTH'(smsb) << (WIDTH-1));         did_step = 1'b1; end
        3'd2: begin m_q = (m_q << 1) | WIDTH'(slsb);                         did_step = 1'b1; end
        3'd3: begin m_q = (m_q >> 1) | (WIDTH'(m_q[0]) << (WIDTH-1));       did_step = 1'b1; end
        3'd4: begin m_q = (m_q << 1) | WIDTH'(m_q[WIDTH-1]);                did_step = 1'b1; end
        3'd5: begin m_q = pd; m_steps = 0; end
        3'd6: begin m_q = '0; m_steps = 0; end
        default: ;
      endcase
    end
    if (did_step) begin
      m_steps++;
      if (m_steps % WIDTH == 0) m_wd = 1'b1;
    end
  endfunction

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic do_cycle(input bit e, input logic [2:0] m, input bit smsb, input bit slsb,
                          input logic [WIDTH-1:0] pd, input string tag);
    en = e; mode = m; sin_msb = smsb; sin_lsb = slsb; pdata = pd;
    @(posedge clock);
    model_apply(e, m, smsb, slsb, pd);
    @(negedge clock);
    cyc++;
    $display("[TB] %s cyc=%0d en=%0b mode=%0d q=%b cnt=%0d wd=%0b",
             tag, cyc, e, m, q, cnt, word_done);
    check_state(tag);
  endtask

  // Pulses clear between edges and checks the immediate asynchronous effect.
  task automatic async_clear(input string tag);
    #2 clear = 1'b1;
    #1;
    m_q = '0; m_steps = 0; m_wd = 1'b0;
    $display("[TB] %s async clear q=%b cnt=%0d wd=%0b", tag, q, cnt, word_done);
    check_state(tag);
    @(posedge clock);
    #1 check_state({tag, ".held"});
    @(negedge clock);
    clear = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_shr_q [4] = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
  logic [WIDTH-1:0] exp_rol_q [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
  bit               exp_sout  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit               shl_seq   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int pulse_cyc[$];
    logic [2:0] rm;

    #1 check_state("reset");
    @(negedge clock);
    clear = 1'b0;

    // Reset mid-operation.
    do_cycle(1, 3'd5, 0, 0, 4'b0111, "rst.load");
    do_cycle(1, 3'd4, 0, 0, '0, "rst.rol");
    do_cycle(1, 3'd4, 0, 0, '0, "rst.rol");
    check("rst.pre_q", 32'(q), 32'(4'b1101));
    check("rst.pre_cnt", 32'(cnt), 32'd2);
    async_clear("rst.clr");
    check("rst.post_q", 32'(q), 32'd0);

    // Load then shift right.
    do_cycle(1, 3'd5, 0, 0, 4'b1011, "shr.load");
    for (int i = 0; i < 4; i++) begin
      check("shr.sout_before", 32'(sout_lsb), 32'(exp_sout[i]));
      do_cycle(1, 3'd1, 0, 0, '0, "shr.step");
      check("shr.q_const", 32'(q), 32'(exp_shr_q[i]));
      check("shr.cnt_const", 32'(cnt), 32'((i + 1) % 4));
      check("shr.wd_const", 32'(word_done), 32'(i == 3));
    end
    do_cycle(1, 3'd0, 0, 0, '0, "shr.hold");

    // Rotate wrap, two back-to-back words.
    do_cycle(1, 3'd5, 0, 0, 4'b1011, "rol.load");
    for (int i = 0; i < 8; i++) begin
      do_cycle(1, 3'd4, 0, 0, '0, "rol.step");
      if (i < 4) check("rol.q_const", 32'(q), 32'(exp_rol_q[i]));
      if (word_done) pulse_cyc.push_back(cyc);
    end
    check("rol.pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2)
      check("rol.spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);

    // Shift-left deserialize.
    do_cycle(1, 3'd6, 0, 0, '0, "shl.sclr");
    for (int i = 0; i < 4; i++) do_cycle(1, 3'd2, 0, shl_seq[i], '0, "shl.step");
    check("shl.q_const", 32'(q), 32'(4'b1001));
    check("shl.wd_const", 32'(word_done), 32'd1);

    // Enable gating and LOAD abort.
    do_cycle(1, 3'd6, 0, 0, '0, "ena.sclr");
    do_cycle(1, 3'd1, 1, 0, '0, "ena.step");
    do_cycle(1, 3'd1, 0, 0, '0, "ena.step");
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 3'd1, 1, 1, 4'hF, "ena.off");
      check("ena.cnt_hold", 32'(cnt), 32'd2);
    end
    do_cycle(1, 3'd1, 1, 0, '0, "ena.step");
    do_cycle(1, 3'd1, 0, 0, '0, "ena.step");
    check("ena.wd_const", 32'(word_done), 32'd1);
    for (int i = 0; i < 3; i++) do_cycle(1, 3'd3, 0, 0, '0, "ena.ror");
    do_cycle(1, 3'd5, 0, 0, 4'b0110, "ena.load_abort");
    check("ena.abort_cnt", 32'(cnt), 32'd0);
    check("ena.abort_wd", 32'(word_done), 32'd0);

    // Reserved code and synchronous clear.
    do_cycle(1, 3'd2, 0, 1, '0, "rsv.shl");
    for (int i = 0; i < 5; i++) do_cycle(1, 3'd7, 1, 1, 4'h9, "rsv.rsvd");
    check("rsv.q_const", 32'(q), 32'(4'b1101));
    check("rsv.cnt_const", 32'(cnt), 32'd1);
    do_cycle(1, 3'd6, 0, 0, '0, "rsv.sclr");

    // Randomized traffic, step-heavy, with occasional asynchronous clears.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_clear("rnd.clr");
      end else begin
        rm = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
        do_cycle($urandom_range(0, 7) != 0, rm, 1'($urandom), 1'($urandom),
                 WIDTH'($urandom), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
